qeciphy_rx_controller_ml: RTL and testbench

Multi-lane successor to the single-lane RX controller. It gates receiver enable, declares link-ready once all NUM_LANES lanes are locked, and tolerates a bounded rate of CRC/FAW errors through a leaky-bucket budget. It also adds a training lock timeout and a selectable relock-on-lock-loss mode. Sits between the per-lane RX datapaths (lock/CRC/FAW detectors) and the link-level status/CSR logic.

---
 rtl/qeciphy_rx_controller_ml.sv | 187 ++++++++++++++++++
 tb/tb_qeciphy_rx_controller_ml.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_rx_controller_ml.sv
// Multi-lane RX link controller: gates receiver enable, declares link-ready once every lane
// is locked, tolerates a leaky-bucket budget of CRC/FAW errors, and bounds training time.
package qeciphy_pkg;
    typedef enum logic [3:0] {
        NO_ERROR           = 4'd0,
        CRC_ERROR          = 4'd1,
        FAW_ERROR          = 4'd2,
        LOCK_TIMEOUT_ERROR = 4'd3,
        LOCK_LOST_ERROR    = 4'd4
    } qeciphy_error_t;
endpackage

module qeciphy_rx_controller_ml
    import qeciphy_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int ERR_BUDGET   = 0,
    parameter int DECAY_PERIOD = 1024,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RELOCK_EN    = 0,
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int CNT_W  = (ERR_BUDGET > 0) ? $clog2(ERR_BUDGET + 1) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [NUM_LANES-1:0] rx_locked_i,
    input  logic [NUM_LANES-1:0] crc_err_i,
    input  logic [NUM_LANES-1:0] faw_err_i,
    output logic                 rx_enable_o,
    output logic                 rx_rdy_o,
    output logic                 rx_fault_fatal_o,
    output logic [3:0]           rx_error_code_o,
    output logic [LANE_W-1:0]    rx_fault_lane_o,
    output logic [CNT_W-1:0]     err_cnt_o
);

    localparam int TIMER_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int DECAY_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);
    localparam logic [CNT_W-1:0]   BUCKET_MAX = CNT_W'(ERR_BUDGET);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_TRAINING,
        ST_READY,
        ST_FAULT
    } state_t;

    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [DECAY_W-1:0]  r_decay;
    logic [CNT_W-1:0]    r_bucket;
    qeciphy_error_t      r_code;
    logic [LANE_W-1:0]   r_lane;
    logic                r_rxEnable;
    logic                r_rxRdy;
    logic                r_fatal;

    state_t              w_nextState;
    logic [TIMER_W-1:0]  w_nextTimer;
    logic [DECAY_W-1:0]  w_nextDecay;
    logic [CNT_W-1:0]    w_nextBucket;
    qeciphy_error_t      w_nextCode;
    logic [LANE_W-1:0]   w_nextLane;
    logic                w_allLocked;
    logic                w_anyCrc;
    logic                w_anyErr;
    logic                w_decayWrap;

    function automatic logic [LANE_W-1:0] lowestSet(input logic [NUM_LANES-1:0] v);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (v[i]) idx = LANE_W'(i);
        end
        return idx;
    endfunction

    assign w_allLocked = &rx_locked_i;
    assign w_anyCrc    = |crc_err_i;
    assign w_anyErr    = w_anyCrc | (|faw_err_i);
    assign w_decayWrap = (r_decay == DECAY_LAST);

    // Counters default to cleared; only the states that own them carry them forward.
    always_comb begin
        w_nextState  = r_state;
        w_nextTimer  = '0;
        w_nextDecay  = '0;
        w_nextBucket = '0;
        w_nextCode   = NO_ERROR;
        w_nextLane   = '0;
        if (!enable_i) begin
            w_nextState = ST_DISABLED;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_nextState = ST_TRAINING;
                end
                ST_TRAINING: begin
                    if (w_allLocked && !w_anyErr) begin
                        w_nextState = ST_READY;
                    end else if ((LOCK_TIMEOUT != 0) && (r_timer == TIMER_LAST)) begin
                        w_nextState = ST_FAULT;
                        w_nextCode  = LOCK_TIMEOUT_ERROR;
                        w_nextLane  = lowestSet(~rx_locked_i);
                    end else begin
                        w_nextTimer = r_timer + TIMER_W'(1);
                    end
                end
                ST_READY: begin
                    w_nextBucket = r_bucket;
                    if (!w_allLocked) begin
                        if (RELOCK_EN != 0) begin
                            w_nextState  = ST_TRAINING;
                            w_nextBucket = '0;
                        end else begin
                            w_nextState = ST_FAULT;
                            w_nextCode  = LOCK_LOST_ERROR;
                            w_nextLane  = lowestSet(~rx_locked_i);
                        end
                    end else begin
                        w_nextDecay = w_decayWrap ? '0 : r_decay + DECAY_W'(1);
                        // A tolerated error and a decay tick in the same cycle cancel out.
                        if (w_anyErr) begin
                            if (r_bucket == BUCKET_MAX) begin
                                w_nextState = ST_FAULT;
                                if (w_anyCrc) begin
                                    w_nextCode = CRC_ERROR;
                                    w_nextLane = lowestSet(crc_err_i);
                                end else begin
                                    w_nextCode = FAW_ERROR;
                                    w_nextLane = lowestSet(faw_err_i);
                                end
                            end else if (!w_decayWrap) begin
                                w_nextBucket = r_bucket + CNT_W'(1);
                            end
                        end else if (w_decayWrap && (r_bucket != '0)) begin
                            w_nextBucket = r_bucket - CNT_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    w_nextBucket = r_bucket;
                    w_nextCode   = r_code;
                    w_nextLane   = r_lane;
                end
                default: begin
                    w_nextState = ST_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_DISABLED;
            r_timer    <= '0;
            r_decay    <= '0;
            r_bucket   <= '0;
            r_code     <= NO_ERROR;
            r_lane     <= '0;
            r_rxEnable <= 1'b0;
            r_rxRdy    <= 1'b0;
            r_fatal    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_timer    <= w_nextTimer;
            r_decay    <= w_nextDecay;
            r_bucket   <= w_nextBucket;
            r_code     <= w_nextCode;
            r_lane     <= w_nextLane;
            r_rxEnable <= (w_nextState == ST_TRAINING) || (w_nextState == ST_READY);
            r_rxRdy    <= (w_nextState == ST_READY);
            r_fatal    <= (w_nextState == ST_FAULT);
        end
    end

    assign rx_enable_o      = r_rxEnable;
    assign rx_rdy_o         = r_rxRdy;
    assign rx_fault_fatal_o = r_fatal;
    assign rx_error_code_o  = r_code;
    assign rx_fault_lane_o  = r_lane;
    assign err_cnt_o        = r_bucket;

endmodule

// File: tb/tb_qeciphy_rx_controller_ml.sv
// Bench for qeciphy_rx_controller_ml: three configurations share one stimulus stream; a
// behavioural model feeds per-instance scoreboards that a monitor drains every cycle.
module tb_qeciphy_rx_controller_ml;

    localparam logic [3:0] C_NONE = 4'd0;
    localparam logic [3:0] C_CRC  = 4'd1;
    localparam logic [3:0] C_FAW  = 4'd2;
    localparam logic [3:0] C_TMO  = 4'd3;
    localparam logic [3:0] C_LOST = 4'd4;

    localparam int M_OFF   = 0;
    localparam int M_TRAIN = 1;
    localparam int M_LINK  = 2;
    localparam int M_DEAD  = 3;

    typedef struct {
        int eb;
        int dp;
        int lt;
        int relock;
        int mode;
        int trainCycles;
        int readyCycles;
        int bucket;
        int code;
        int lane;
    } model_t;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        fatal;
        logic [3:0]  code;
        logic [1:0]  lane;
        logic [31:0] cnt;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] rxLocked;
    logic [3:0] crcErr;
    logic [3:0] fawErr;

    logic enA, rdyA, fatalA, enB, rdyB, fatalB, enC, rdyC, fatalC;
    logic [3:0] codeA, codeB, codeC;
    logic [1:0] laneA, laneB, laneC;
    logic [1:0] cntA;
    logic       cntB;
    logic       cntC;

    int checks = 0;
    int errors = 0;

    model_t mdl[3];
    exp_t   qA[$];
    exp_t   qB[$];
    exp_t   qC[$];

    qeciphy_rx_controller_ml #(
        .NUM_LANES(4), .ERR_BUDGET(3), .DECAY_PERIOD(8), .LOCK_TIMEOUT(16), .RELOCK_EN(0)
    ) dutA (
        .clk_i(clock), .rst_i(reset), .enable_i(enable), .rx_locked_i(rxLocked),
        .crc_err_i(crcErr), .faw_err_i(fawErr), .rx_enable_o(enA), .rx_rdy_o(rdyA),
        .rx_fault_fatal_o(fatalA), .rx_error_code_o(codeA), .rx_fault_lane_o(laneA),
        .err_cnt_o(cntA)
    );

    qeciphy_rx_controller_ml dutB (
        .clk_i(clock), .rst_i(reset), .enable_i(enable), .rx_locked_i(rxLocked),
        .crc_err_i(crcErr), .faw_err_i(fawErr), .rx_enable_o(enB), .rx_rdy_o(rdyB),
        .rx_fault_fatal_o(fatalB), .rx_error_code_o(codeB), .rx_fault_lane_o(laneB),
        .err_cnt_o(cntB)
    );

    qeciphy_rx_controller_ml #(
        .NUM_LANES(4), .ERR_BUDGET(1), .DECAY_PERIOD(4), .LOCK_TIMEOUT(0), .RELOCK_EN(1)
    ) dutC (
        .clk_i(clock), .rst_i(reset), .enable_i(enable), .rx_locked_i(rxLocked),
        .crc_err_i(crcErr), .faw_err_i(fawErr), .rx_enable_o(enC), .rx_rdy_o(rdyC),
        .rx_fault_fatal_o(fatalC), .rx_error_code_o(codeC), .rx_fault_lane_o(laneC),
        .err_cnt_o(cntC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic model_t newModel(int eb, int dp, int lt, int relock);
        model_t m;
        m.eb = eb; m.dp = dp; m.lt = lt; m.relock = relock;
        m.mode = M_OFF; m.trainCycles = 0; m.readyCycles = 0;
        m.bucket = 0; m.code = 0; m.lane = 0;
        return m;
    endfunction

    function automatic int firstIndex(logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Behavioural reference: one call per clock edge, written from the link rules directly.
    function automatic model_t modelStep(model_t m, logic rst, logic en, logic [3:0] locked,
                                         logic [3:0] crc, logic [3:0] faw);
        model_t n;
        bit allLocked;
        bit anyErr;
        bit decayTick;
        n = m;
        allLocked = (locked == 4'hF);
        anyErr = (crc != 4'h0) || (faw != 4'h0);
        if (rst || !en) begin
            return newModel(m.eb, m.dp, m.lt, m.relock);
        end
        case (m.mode)
            M_OFF: begin
                n.mode = M_TRAIN;
                n.trainCycles = 0;
            end
            M_TRAIN: begin
                if (allLocked && !anyErr) begin
                    n.mode = M_LINK; n.bucket = 0; n.readyCycles = 0;
                end else if (m.lt != 0 && m.trainCycles + 1 == m.lt) begin
                    n.mode = M_DEAD; n.code = C_TMO; n.lane = firstIndex(~locked);
                end else begin
                    n.trainCycles = m.trainCycles + 1;
                end
            end
            M_LINK: begin
                decayTick = ((m.readyCycles % m.dp) == m.dp - 1);
                n.readyCycles = m.readyCycles + 1;
                if (!allLocked) begin
                    if (m.relock != 0) begin
                        n.mode = M_TRAIN; n.trainCycles = 0; n.bucket = 0;
                    end else begin
                        n.mode = M_DEAD; n.code = C_LOST; n.lane = firstIndex(~locked);
                    end
                end else if (anyErr) begin
                    if (m.bucket == m.eb) begin
                        n.mode = M_DEAD;
                        n.code = (crc != 4'h0) ? C_CRC : C_FAW;
                        n.lane = (crc != 4'h0) ? firstIndex(crc) : firstIndex(faw);
                    end else if (!decayTick) begin
                        n.bucket = m.bucket + 1;
                    end
                end else if (decayTick && m.bucket > 0) begin
                    n.bucket = m.bucket - 1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic exp_t expectOf(model_t m);
        exp_t e;
        e.en    = (m.mode == M_TRAIN) || (m.mode == M_LINK);
        e.rdy   = (m.mode == M_LINK);
        e.fatal = (m.mode == M_DEAD);
        e.code  = (m.mode == M_DEAD) ? 4'(m.code) : C_NONE;
        e.lane  = (m.mode == M_DEAD) ? 2'(m.lane) : 2'd0;
        e.cnt   = (m.mode == M_LINK || m.mode == M_DEAD) ? 32'(m.bucket) : 32'd0;
        return e;
    endfunction

    function automatic exp_t mk(logic en, logic rdy, logic fatal, logic [3:0] code,
                                logic [1:0] lane, int cnt);
        exp_t e;
        e.en = en; e.rdy = rdy; e.fatal = fatal; e.code = code; e.lane = lane;
        e.cnt = 32'(cnt);
        return e;
    endfunction

    function automatic exp_t actualOf(int k);
        exp_t a;
        case (k)
            0: begin
                a.en = enA; a.rdy = rdyA; a.fatal = fatalA; a.code = codeA;
                a.lane = laneA; a.cnt = 32'(cntA);
            end
            1: begin
                a.en = enB; a.rdy = rdyB; a.fatal = fatalB; a.code = codeB;
                a.lane = laneB; a.cnt = 32'(cntB);
            end
            default: begin
                a.en = enC; a.rdy = rdyC; a.fatal = fatalC; a.code = codeC;
                a.lane = laneC; a.cnt = 32'(cntC);
            end
        endcase
        return a;
    endfunction

    task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(string tag, exp_t act, exp_t exp);
        checkField({tag, ".rx_enable"}, 32'(act.en), 32'(exp.en));
        checkField({tag, ".rx_rdy"}, 32'(act.rdy), 32'(exp.rdy));
        checkField({tag, ".fatal"}, 32'(act.fatal), 32'(exp.fatal));
        checkField({tag, ".code"}, 32'(act.code), 32'(exp.code));
        checkField({tag, ".lane"}, 32'(act.lane), 32'(exp.lane));
        checkField({tag, ".err_cnt"}, act.cnt, exp.cnt);
    endtask

    task automatic applyStimulus(logic r, logic e, logic [3:0] lk, logic [3:0] cr, logic [3:0] fw);
        @(negedge clock);
        reset = r; enable = e; rxLocked = lk; crcErr = cr; fawErr = fw;
        for (int k = 0; k < 3; k++) mdl[k] = modelStep(mdl[k], r, e, lk, cr, fw);
        qA.push_back(expectOf(mdl[0]));
        qB.push_back(expectOf(mdl[1]));
        qC.push_back(expectOf(mdl[2]));
    endtask

    task automatic idle(int n, logic [3:0] lk);
        repeat (n) applyStimulus(1'b0, 1'b1, lk, 4'h0, 4'h0);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Scoreboard monitor: outputs are valid every cycle, one expectation per edge.
    always @(posedge clock) begin
        #1;
        if (qA.size() > 0) checkOutput("A", actualOf(0), qA.pop_front());
        if (qB.size() > 0) checkOutput("B", actualOf(1), qB.pop_front());
        if (qC.size() > 0) checkOutput("C", actualOf(2), qC.pop_front());
    end

    initial begin
        logic       r, e;
        logic [3:0] lk, cr, fw;
        bit         badPhase;
        reset = 1'b1; enable = 1'b0; rxLocked = 4'h0; crcErr = 4'h0; fawErr = 4'h0;
        badPhase = 1'b0;
        mdl[0] = newModel(3, 8, 16, 0);
        mdl[1] = newModel(0, 1024, 65535, 0);
        mdl[2] = newModel(1, 4, 0, 1);

        // Bring-up with lock arriving on the third enabled cycle
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        settle();
        checkOutput("reset.A", actualOf(0), mk(0, 0, 0, C_NONE, 0, 0));
        applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        settle();
        checkOutput("enable.A", actualOf(0), mk(1, 0, 0, C_NONE, 0, 0));
        applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0);
        settle();
        checkOutput("lock.A", actualOf(0), mk(1, 1, 0, C_NONE, 0, 0));

        // CRC beats FAW on a zero-budget instance
        applyStimulus(1'b0, 1'b1, 4'hF, 4'b0100, 4'b0001);
        settle();
        checkOutput("crcfault.B", actualOf(1), mk(0, 0, 1, C_CRC, 2, 0));
        checkOutput("tolerate.A", actualOf(0), mk(1, 1, 0, C_NONE, 0, 1));
        idle(100, 4'hF);
        settle();
        checkOutput("sticky.B", actualOf(1), mk(0, 0, 1, C_CRC, 2, 0));
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
        settle();
        checkOutput("disable.B", actualOf(1), mk(0, 0, 0, C_NONE, 0, 0));

        // Leaky bucket: fault on the fourth back-to-back error
        idle(2, 4'hF);
        repeat (3) applyStimulus(1'b0, 1'b1, 4'hF, 4'b0010, 4'h0);
        settle();
        checkOutput("bucket3.A", actualOf(0), mk(1, 1, 0, C_NONE, 0, 3));
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'b1000);
        settle();
        checkOutput("overflow.A", actualOf(0), mk(0, 0, 1, C_FAW, 3, 3));

        // Same, with nine quiet cycles so one decay tick lands first
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
        idle(2, 4'hF);
        repeat (3) applyStimulus(1'b0, 1'b1, 4'hF, 4'b0010, 4'h0);
        idle(9, 4'hF);
        settle();
        checkOutput("decayed.A", actualOf(0), mk(1, 1, 0, C_NONE, 0, 2));
        applyStimulus(1'b0, 1'b1, 4'hF, 4'b0001, 4'h0);
        settle();
        checkOutput("survive.A", actualOf(0), mk(1, 1, 0, C_NONE, 0, 3));

        // Training timeout on the sixteenth cycle, then lock exactly on that cycle
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
        idle(16, 4'b1011);
        settle();
        checkOutput("pretimeout.A", actualOf(0), mk(1, 0, 0, C_NONE, 0, 0));
        applyStimulus(1'b0, 1'b1, 4'b1011, 4'h0, 4'h0);
        settle();
        checkOutput("timeout.A", actualOf(0), mk(0, 0, 1, C_TMO, 2, 0));
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
        idle(16, 4'b1011);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0);
        settle();
        checkOutput("lastlock.A", actualOf(0), mk(1, 1, 0, C_NONE, 0, 0));

        // Lane 1 drops lock: fatal without relock, retrain with it
        idle(1, 4'hF);
        applyStimulus(1'b0, 1'b1, 4'b1101, 4'h0, 4'h0);
        settle();
        checkOutput("lost.A", actualOf(0), mk(0, 0, 1, C_LOST, 1, 0));
        checkOutput("relock.C", actualOf(2), mk(1, 0, 0, C_NONE, 0, 0));
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0);
        settle();
        checkOutput("relocked.C", actualOf(2), mk(1, 1, 0, C_NONE, 0, 0));

        // One-cycle reset with enable held high
        applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h0);
        settle();
        checkOutput("rstfault.B", actualOf(1), mk(0, 0, 0, C_NONE, 0, 0));
        checkOutput("rstready.C", actualOf(2), mk(0, 0, 0, C_NONE, 0, 0));
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0);
        settle();
        checkOutput("resume.A", actualOf(0), mk(1, 0, 0, C_NONE, 0, 0));

        // Randomized traffic with occasional long unlocked stretches
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) badPhase = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 149) != 0);
            lk = badPhase ? 4'($urandom) : (($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'hF);
            cr = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
            fw = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
            applyStimulus(r, e, lk, cr, fw);
        end

        settle();
        checkField("drain", 32'(qA.size() + qB.size() + qC.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
